// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding,
// opcode values, instruction field positions and the legality check.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  typedef logic [31:0] instr_t;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SHL   = 6'h05;
  localparam logic [5:0] OP_MEMRD = 6'h06;
  localparam logic [5:0] OP_MEMWR = 6'h07;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // HALT is not "legal": it ends the program without ever being issued.
  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    if (op <= OP_MEMWR) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// Program memory: DEPTH x 32, synchronous write, registered read, no reset.
module prog_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read data only updates on re_i so it doubles as the instruction register.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words from program memory and issues
// decoded opcode/address/data to a processor with a valid/ready handshake.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     start,
  input  logic                     issue_ready,
  output logic                     issue_valid,
  output logic [5:0]               opcode_o,
  output logic [31:0]              addr_o,
  output logic [31:0]              write_data_o,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] pc_o,
  output logic [15:0]              issue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   count_q, count_d;
  logic          fetch_s;
  logic          wr_en_s;
  instr_t        ir_s;
  logic [5:0]    op_s;
  logic          legal_s;

  assign wr_en_s = load_en && !busy;

  prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_prog_ram (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (fetch_s),
    .raddr_i (pc_q),
    .rdata_o (ir_s)
  );

  assign op_s    = ir_s[OPC_MSB:OPC_LSB];
  assign legal_s = op_legal(op_s);

  // State, program counter and issue counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    fetch_s      = 1'b0;
    issue_valid  = 1'b0;
    opcode_o     = OP_HALT;
    addr_o       = 32'd0;
    write_data_o = 32'd0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          pc_d    = '0;
          count_d = 16'd0;
          state_d = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        fetch_s = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (op_s == OP_HALT) begin
          state_d = S_DONE;
        end else if (!legal_s) begin
          state_d = S_ERR;
        end else begin
          issue_valid  = 1'b1;
          opcode_o     = op_s;
          addr_o       = {22'd0, ir_s[ADDR_MSB:ADDR_LSB]};
          write_data_o = {16'd0, ir_s[IMM_MSB:IMM_LSB]};
          if (issue_ready) begin
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end else begin
              count_d = count_q;
            end
            // The last word ends the program in place; pc never wraps.
            if (pc_q == PC_LAST) begin
              state_d = S_DONE;
            end else begin
              pc_d    = pc_q + AW'(1);
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign pc_o        = pc_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (DEPTH=4 so the
// end-of-memory path is reachable with short programs).
module tb_instr_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        issue_ready;
  logic        issue_valid;
  logic [5:0]  opcode_o;
  logic [31:0] addr_o;
  logic [31:0] write_data_o;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  pc_o;
  logic [15:0] issue_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_iss;
  logic bad3;

  instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .issue_ready  (issue_ready),
    .issue_valid  (issue_valid),
    .opcode_o     (opcode_o),
    .addr_o       (addr_o),
    .write_data_o (write_data_o),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .pc_o         (pc_o),
    .issue_count  (issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [9:0] a,
                                     input logic [15:0] imm);
    return {op, a, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs until done/error (bounded), counting accepted issues and noting
  // any issue_valid while pc sits at address 3.
  task automatic run_to_end(output int n, output logic at3);
    n   = 0;
    at3 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || error) break;
      if (issue_valid && issue_ready) n++;
      if (issue_valid && pc_o == 2'd3) at3 = 1'b1;
      step();
    end
    chk("run_terminated", {31'd0, done | error}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},        32'd0);
    chk({tag, "_done"},  {31'd0, done},        32'd0);
    chk({tag, "_err"},   {31'd0, error},       32'd0);
    chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd0);
    chk({tag, "_op"},    {26'd0, opcode_o},    32'h3F);
    chk({tag, "_addr"},  addr_o,               32'd0);
    chk({tag, "_wd"},    write_data_o,         32'd0);
    chk({tag, "_pc"},    {30'd0, pc_o},        32'd0);
    chk({tag, "_cnt"},   {16'd0, issue_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = 2'd0; load_data = 32'd0;
    start = 1'b0; issue_ready = 1'b0;
    step(); step();
    chk_reset_outputs("rst");
    reset = 1'b0;

    // Basic program, ready held high: issues two cycles apart then HALT.
    load(2'd0, mk(6'h00, 10'd5, 16'h0010));
    load(2'd1, mk(6'h07, 10'd9, 16'h1234));
    load(2'd2, mk(6'h3F, 10'd0, 16'h0000));
    issue_ready = 1'b1;
    pulse_start();
    chk("p1_fetch_busy",  {31'd0, busy},        32'd1);
    chk("p1_fetch_valid", {31'd0, issue_valid}, 32'd0);
    chk("p1_fetch_op",    {26'd0, opcode_o},    32'h3F);
    step();
    chk("p1_i0_valid", {31'd0, issue_valid}, 32'd1);
    chk("p1_i0_op",    {26'd0, opcode_o},    32'h00);
    chk("p1_i0_addr",  addr_o,               32'd5);
    chk("p1_i0_wd",    write_data_o,         32'h10);
    step();
    chk("p1_gap_valid", {31'd0, issue_valid}, 32'd0);
    chk("p1_gap_addr",  addr_o,               32'd0);
    chk("p1_gap_cnt",   {16'd0, issue_count}, 32'd1);
    step();
    chk("p1_i1_valid", {31'd0, issue_valid}, 32'd1);
    chk("p1_i1_op",    {26'd0, opcode_o},    32'h07);
    chk("p1_i1_addr",  addr_o,               32'd9);
    chk("p1_i1_wd",    write_data_o,         32'h1234);
    step();
    step();
    chk("p1_halt_valid", {31'd0, issue_valid}, 32'd0);
    chk("p1_halt_op",    {26'd0, opcode_o},    32'h3F);
    step();
    chk("p1_done", {31'd0, done},        32'd1);
    chk("p1_busy", {31'd0, busy},        32'd0);
    chk("p1_cnt",  {16'd0, issue_count}, 32'd2);
    chk("p1_pc",   {30'd0, pc_o},        32'd2);

    // Same program restarted from DONE with a 5-cycle stall on the first issue.
    issue_ready = 1'b0;
    pulse_start();
    chk("p2_cnt_cleared", {16'd0, issue_count}, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("p2_stall_valid", {31'd0, issue_valid}, 32'd1);
      chk("p2_stall_op",    {26'd0, opcode_o},    32'h00);
      chk("p2_stall_addr",  addr_o,               32'd5);
      chk("p2_stall_wd",    write_data_o,         32'h10);
      chk("p2_stall_cnt",   {16'd0, issue_count}, 32'd0);
      step();
    end
    issue_ready = 1'b1;
    step();
    chk("p2_acc_cnt",   {16'd0, issue_count}, 32'd1);
    chk("p2_acc_valid", {31'd0, issue_valid}, 32'd0);
    step();
    chk("p2_i1_op", {26'd0, opcode_o}, 32'h07);
    step(); step(); step();
    chk("p2_done", {31'd0, done},        32'd1);
    chk("p2_cnt",  {16'd0, issue_count}, 32'd2);

    // Illegal opcode 6'h15 at address 3.
    load(2'd0, mk(6'h01, 10'd1, 16'd1));
    load(2'd1, mk(6'h02, 10'd2, 16'd2));
    load(2'd2, mk(6'h03, 10'd3, 16'd3));
    load(2'd3, mk(6'h15, 10'd3, 16'd3));
    pulse_start();
    run_to_end(n_iss, bad3);
    chk("p3_error",   {31'd0, error},       32'd1);
    chk("p3_done",    {31'd0, done},        32'd0);
    chk("p3_pc",      {30'd0, pc_o},        32'd3);
    chk("p3_cnt",     {16'd0, issue_count}, 32'd3);
    chk("p3_nissue",  n_iss,                32'd3);
    chk("p3_valid@3", {31'd0, bad3},        32'd0);
    chk("p3_err_op",  {26'd0, opcode_o},    32'h3F);

    // No HALT: runs off the end of memory and stops at pc=3.
    load(2'd3, mk(6'h04, 10'd4, 16'd4));
    pulse_start();
    run_to_end(n_iss, bad3);
    chk("p4_done",   {31'd0, done},        32'd1);
    chk("p4_error",  {31'd0, error},       32'd0);
    chk("p4_pc",     {30'd0, pc_o},        32'd3);
    chk("p4_cnt",    {16'd0, issue_count}, 32'd4);
    chk("p4_nissue", n_iss,                32'd4);

    // load_en and start while busy: both ignored.
    pulse_start();
    load_en = 1'b1; load_addr = 2'd0; load_data = mk(6'h3F, 10'd0, 16'd0);
    start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("p5_i0_valid", {31'd0, issue_valid}, 32'd1);
    chk("p5_i0_op",    {26'd0, opcode_o},    32'h01);
    chk("p5_i0_addr",  addr_o,               32'd1);
    run_to_end(n_iss, bad3);
    chk("p5_nissue", n_iss,                32'd4);
    chk("p5_cnt",    {16'd0, issue_count}, 32'd4);
    chk("p5_done",   {31'd0, done},        32'd1);
    issue_ready = 1'b0;
    pulse_start();
    step();
    chk("p5_mem_kept_valid", {31'd0, issue_valid}, 32'd1);
    chk("p5_mem_kept_op",    {26'd0, opcode_o},    32'h01);
    chk("p5_mem_kept_wd",    write_data_o,         32'd1);

    // Reset during a stalled ISSUE, then re-run the retained program.
    reset = 1'b1;
    step();
    chk_reset_outputs("p6");
    reset = 1'b0;
    issue_ready = 1'b1;
    pulse_start();
    step();
    chk("p6_i0_op",   {26'd0, opcode_o}, 32'h01);
    chk("p6_i0_addr", addr_o,            32'd1);
    run_to_end(n_iss, bad3);
    chk("p6_nissue", n_iss,                32'd4);
    chk("p6_cnt",    {16'd0, issue_count}, 32'd4);
    chk("p6_pc",     {30'd0, pc_o},        32'd3);
    chk("p6_done",   {31'd0, done},        32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: DEPTH, 64, program-memory words (power of two, 2..1024).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load_en  input  1  program-memory write strobe.
REQ-005 load_addr  input  $clog2(DEPTH)  program-memory write address.
REQ-006 load_data  input  32  instruction word to write.
REQ-007 start  input  1  single-cycle run request.
REQ-008 issue_ready  input  1  downstream processor accepts the current issue.
REQ-009 issue_valid  output  1  opcode_o/addr_o/write_data_o hold a legal instruction.
REQ-010 opcode_o  output  6  opcode to the processor.
REQ-011 addr_o  output  32  data-memory address to the processor.
REQ-012 write_data_o  output  32  store data to the processor.
REQ-013 busy  output  1  sequencer in FETCH or ISSUE.
REQ-014 done  output  1  level, program ended by HALT or end of memory.
REQ-015 error  output  1  level, program stopped on an illegal opcode.
REQ-016 pc_o  output  $clog2(DEPTH)  current program counter.
REQ-017 issue_count  output  16  instructions accepted since the last start, saturating at 16'hFFFF.

Function
REQ-018 Instruction word format: [31:26] opcode; [25:16] data address, zero-extended to 32 bits; [15:0] immediate, zero-extended to 32 bits.
REQ-019 Legal opcodes are 6'h00..6'h07; 6'h3F is HALT; every other opcode is illegal.
REQ-020 The state machine SHALL have states IDLE, FETCH, ISSUE, DONE and ERR.
REQ-021 In IDLE, DONE or ERR, start SHALL clear pc and issue_count and move to FETCH on the next edge.
REQ-022 start received in FETCH or ISSUE SHALL be ignored.
REQ-023 load_en SHALL write load_data to program memory only in IDLE, DONE or ERR; it is ignored while busy.
REQ-024 FETCH SHALL register prog[pc] into the instruction register and move to ISSUE; the read latency is 1 cycle.
REQ-025 In ISSUE with HALT, the sequencer SHALL move to DONE without asserting issue_valid.
REQ-026 In ISSUE with an illegal opcode, the sequencer SHALL move to ERR without asserting issue_valid, and pc_o SHALL hold the offending address.
REQ-027 In ISSUE with a legal opcode, issue_valid SHALL be 1 and the decoded fields SHALL be driven on the outputs.
REQ-028 The outputs SHALL be held stable until issue_valid && issue_ready.
REQ-029 On acceptance, issue_count SHALL increment (saturating) and pc SHALL increment.
REQ-030 After acceptance, if pc was DEPTH-1 the sequencer SHALL move to DONE (no wrap); otherwise it SHALL move to FETCH.
REQ-031 Issue throughput with issue_ready held high SHALL be one instruction per 2 cycles.
REQ-032 Whenever issue_valid is 0, opcode_o SHALL be 6'h3F (processor no-op), and addr_o and write_data_o SHALL be 0.
REQ-033 busy = (state==FETCH || state==ISSUE); done = (state==DONE); error = (state==ERR).
REQ-034 When load_en targets the instruction currently being fetched, the write is ignored because the sequencer is busy (REQ-023); there is no read-during-write hazard.

Reset
REQ-035 Reset SHALL take effect immediately, in any state, and abort any run in progress.
REQ-036 Reset SHALL force state to IDLE; pc_o, issue_count, busy, done, error and issue_valid to 0; opcode_o to 6'h3F; addr_o and write_data_o to 0.
REQ-037 Program-memory contents SHALL NOT be cleared by reset.

Structure
REQ-038 Package seq_pkg SHALL hold the state enum, the opcode constants (OP_ADD..OP_MEMWR = 6'h00..6'h07, OP_HALT = 6'h3F), the instruction field bit positions, and a 32-bit instruction typedef.
REQ-039 Program memory SHALL be a sub-module prog_ram: DEPTH x 32, synchronous write, registered read, no reset.

Verification
REQ-040 Load {ADD, addr 5, imm 0x10}, {MEMWR, addr 9, imm 0x1234}, HALT; start; ready=1 -> two issues, 2 cycles apart, with opcode/addr/write_data = 00/5/0x10 and 07/9/0x1234; then done=1, issue_count=2, pc_o=2.
REQ-041 Same program with ready low for 5 cycles on the first issue -> outputs stable for all 5 cycles; exactly one acceptance is counted.
REQ-042 Opcode 6'h15 at address 3 -> error=1, pc_o=3, issue_count=3, and issue_valid is never asserted for address 3.
REQ-043 DEPTH=4, no HALT in the program -> 4 issues, then done=1 and pc_o=3 with no wrap to address 0.
REQ-044 Assert reset during ISSUE with ready low -> next cycle state IDLE, all outputs at reset values; a new start re-runs the retained program identically.
REQ-045 load_en and start pulsed while busy -> program memory unchanged and the run unaffected; start from DONE restarts with issue_count reset to 0.
